// File: rtl/branch_pkg.sv
// branch_pkg: shared funct3 encodings, BHT counter states and the saturating counter step
package branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: RV32I branch condition evaluator with illegal-encoding flag
module branch_cmp import branch_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            cond_true,
  output logic            illegal
);
  logic eq, lt, ltu;
  always_comb begin
    eq = a == b;
    lt = $signed(a) < $signed(b);
    ltu = a < b;
    illegal = funct3[2:1] == 2'b01;
    cond_true = funct3 == F3_BEQ  ? eq :
                funct3 == F3_BNE  ? !eq :
                funct3 == F3_BLT  ? lt :
                funct3 == F3_BGE  ? !lt :
                funct3 == F3_BLTU ? ltu :
                funct3 == F3_BGEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch resolution, 2-bit BHT prediction/training and statistics
module branch_predict_unit import branch_pkg::*; #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter int         STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [XLEN-1:0]   res_pc,
  input  logic              res_is_branch,
  input  logic              res_is_jump,
  input  logic [2:0]        res_funct3,
  input  logic              res_pred_taken,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              take_branch,
  output logic              mispredict,
  output logic              illegal_cond,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic [1:0] bht [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx, res_idx;
  logic cond_true, illegal, is_jump, is_br, legal_br;
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a(rs1_data), .b(rs2_data), .funct3(res_funct3), .cond_true(cond_true), .illegal(illegal)
  );
  always_comb begin
    pred_idx = pred_pc[IDX_W+1:2];
    res_idx = res_pc[IDX_W+1:2];
    pred_taken = bht[pred_idx][1];
    is_jump = res_valid & res_is_jump;
    is_br = res_valid & res_is_branch & !res_is_jump;
    illegal_cond = is_br & illegal;
    legal_br = is_br & !illegal;
    take_branch = is_jump | (legal_br & cond_true);
    mispredict = legal_br & (cond_true != res_pred_taken);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (legal_br) begin
      bht[res_idx] <= ctr_next(bht[res_idx], cond_true);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else if (clr_stats) begin
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (legal_br && !(&branch_cnt)) branch_cnt <= branch_cnt + STAT_W'(1);
      if (mispredict && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
  localparam int SW = 8;
  logic clk = 0, rst_n = 0;
  logic [31:0] pred_pc = 0, res_pc = 0, rs1_data = 0, rs2_data = 0;
  logic pred_taken, res_valid = 0, res_is_branch = 0, res_is_jump = 0, res_pred_taken = 0;
  logic [2:0] res_funct3 = 0;
  logic take_branch, mispredict, illegal_cond, clr_stats = 0;
  logic [SW-1:0] branch_cnt, mispredict_cnt;
  int checks = 0, fails = 0;
  int exp_br = 0, exp_mp = 0;

  branch_predict_unit #(.STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
    .res_is_jump(res_is_jump), .res_funct3(res_funct3), .res_pred_taken(res_pred_taken),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .take_branch(take_branch),
    .mispredict(mispredict), .illegal_cond(illegal_cond), .clr_stats(clr_stats),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic [2:0] f3, input logic pt, input logic [31:0] a, input logic [31:0] b);
    res_valid = 1; res_pc = pc; res_is_branch = br; res_is_jump = jmp;
    res_funct3 = f3; res_pred_taken = pt; rs1_data = a; rs2_data = b;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    res_valid = 0; res_is_branch = 0; res_is_jump = 0; clr_stats = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; pred_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred got %b want 0", pred_taken); end
    checks++; if (branch_cnt !== 0) begin fails++; $display("FAIL reset_brcnt got %0d want 0", branch_cnt); end
    checks++; if (mispredict_cnt !== 0) begin fails++; $display("FAIL reset_mpcnt got %0d want 0", mispredict_cnt); end
    checks++; if (take_branch !== 1'b0) begin fails++; $display("FAIL reset_take got %b want 0", take_branch); end
    rst_n = 1;
    step();
  endtask

  task automatic test_beq();
    drive(32'h100, 1, 0, 3'b000, 0, 5, 5);
    checks++; if (take_branch !== 1'b1) begin fails++; $display("FAIL beq_take got %b want 1", take_branch); end
    checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL beq_mp got %b want 1", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL beq_pred_pre got %b want 0", pred_taken); end
    step(); exp_br = 1; exp_mp = 1;
    checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL beq_pred_post got %b want 1", pred_taken); end
    checks++; if (branch_cnt !== 1) begin fails++; $display("FAIL beq_brcnt got %0d want 1", branch_cnt); end
    checks++; if (mispredict_cnt !== 1) begin fails++; $display("FAIL beq_mpcnt got %0d want 1", mispredict_cnt); end
  endtask

  task automatic test_signed();
    drive(32'h104, 1, 0, 3'b100, 1, 32'hFFFF_FFFF, 1);
    checks++; if (take_branch !== 1'b1) begin fails++; $display("FAIL blt_take got %b want 1", take_branch); end
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL blt_mp got %b want 0", mispredict); end
    step(); exp_br++;
    drive(32'h104, 1, 0, 3'b110, 1, 32'hFFFF_FFFF, 1);
    checks++; if (take_branch !== 1'b0) begin fails++; $display("FAIL bltu_take got %b want 0", take_branch); end
    checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL bltu_mp got %b want 1", mispredict); end
    step(); exp_br++; exp_mp++;
    checks++; if (branch_cnt !== exp_br) begin fails++; $display("FAIL signed_brcnt got %0d want %0d", branch_cnt, exp_br); end
    checks++; if (mispredict_cnt !== exp_mp) begin fails++; $display("FAIL signed_mpcnt got %0d want %0d", mispredict_cnt, exp_mp); end
  endtask

  task automatic test_conditions();
    logic [2:0]  f3 [8] = '{3'b000, 3'b001, 3'b101, 3'b111, 3'b100, 3'b101, 3'b001, 3'b110};
    logic [31:0] a  [8] = '{3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 7, 0};
    logic [31:0] b  [8] = '{4, 4, 1, 1, 1, 1, 7, 1};
    logic        ex [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      drive(32'h108, 1, 0, f3[i], 0, a[i], b[i]);
      checks++; if (take_branch !== ex[i]) begin fails++; $display("FAIL cond%0d_take got %b want %b", i, take_branch, ex[i]); end
      checks++; if (mispredict !== ex[i]) begin fails++; $display("FAIL cond%0d_mp got %b want %b", i, mispredict, ex[i]); end
      step(); exp_br++; if (ex[i]) exp_mp++;
    end
    checks++; if (branch_cnt !== exp_br) begin fails++; $display("FAIL cond_brcnt got %0d want %0d", branch_cnt, exp_br); end
    checks++; if (mispredict_cnt !== exp_mp) begin fails++; $display("FAIL cond_mpcnt got %0d want %0d", mispredict_cnt, exp_mp); end
  endtask

  task automatic test_bht_saturation();
    pred_pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      drive(32'h200, 1, 0, 3'b000, 1, 1, 1);
      step(); exp_br++;
      checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL sat_taken%0d got %b want 1", i, pred_taken); end
    end
    drive(32'h200, 1, 0, 3'b001, 1, 1, 1);
    step(); exp_br++; exp_mp++;
    checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL sat_nt1 got %b want 1", pred_taken); end
    drive(32'h200, 1, 0, 3'b001, 1, 1, 1);
    checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL sat_same_cycle got %b want 1", pred_taken); end
    step(); exp_br++; exp_mp++;
    checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL sat_nt2 got %b want 0", pred_taken); end
  endtask

  task automatic test_illegal_and_jump();
    for (int i = 0; i < 2; i++) begin
      drive(32'h300, 1, 0, i == 0 ? 3'b010 : 3'b011, 1, 1, 1);
      checks++; if (illegal_cond !== 1'b1) begin fails++; $display("FAIL ill%0d_flag got %b want 1", i, illegal_cond); end
      checks++; if (take_branch !== 1'b0) begin fails++; $display("FAIL ill%0d_take got %b want 0", i, take_branch); end
      checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL ill%0d_mp got %b want 0", i, mispredict); end
      step();
    end
    drive(32'h300, 1, 1, 3'b000, 0, 1, 1);
    checks++; if (take_branch !== 1'b1) begin fails++; $display("FAIL jal_take got %b want 1", take_branch); end
    checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL jal_mp got %b want 0", mispredict); end
    checks++; if (illegal_cond !== 1'b0) begin fails++; $display("FAIL jal_ill got %b want 0", illegal_cond); end
    step();
    checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL jal_bht got %b want 0", pred_taken); end
    checks++; if (branch_cnt !== exp_br) begin fails++; $display("FAIL ill_brcnt got %0d want %0d", branch_cnt, exp_br); end
    checks++; if (mispredict_cnt !== exp_mp) begin fails++; $display("FAIL ill_mpcnt got %0d want %0d", mispredict_cnt, exp_mp); end
    drive(32'h300, 0, 0, 3'b000, 0, 1, 1);
    res_valid = 0; #1;
    checks++; if (take_branch !== 1'b0) begin fails++; $display("FAIL novalid_take got %b want 0", take_branch); end
    step();
  endtask

  task automatic test_clr();
    drive(32'h10C, 1, 0, 3'b000, 0, 1, 1);
    clr_stats = 1;
    step(); exp_br = 0; exp_mp = 0;
    checks++; if (branch_cnt !== 0) begin fails++; $display("FAIL clr_brcnt got %0d want 0", branch_cnt); end
    checks++; if (mispredict_cnt !== 0) begin fails++; $display("FAIL clr_mpcnt got %0d want 0", mispredict_cnt); end
  endtask

  task automatic test_stat_saturation();
    for (int i = 0; i < 255; i++) begin
      drive(32'h10C, 1, 0, 3'b000, 0, 1, 1);
      step();
    end
    checks++; if (branch_cnt !== 8'hFF) begin fails++; $display("FAIL pre_sat_brcnt got %0d want 255", branch_cnt); end
    drive(32'h10C, 1, 0, 3'b000, 0, 1, 1);
    step();
    checks++; if (branch_cnt !== 8'hFF) begin fails++; $display("FAIL sat_brcnt got %0d want 255", branch_cnt); end
    checks++; if (mispredict_cnt !== 8'hFF) begin fails++; $display("FAIL sat_mpcnt got %0d want 255", mispredict_cnt); end
  endtask

  task automatic test_async_reset();
    pred_pc = 32'h114;
    drive(32'h114, 1, 0, 3'b000, 1, 2, 2);
    step();
    checks++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL arst_pre_pred got %b want 1", pred_taken); end
    #2 rst_n = 0; #1;
    checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL arst_pred got %b want 0", pred_taken); end
    checks++; if (branch_cnt !== 0) begin fails++; $display("FAIL arst_brcnt got %0d want 0", branch_cnt); end
    checks++; if (mispredict_cnt !== 0) begin fails++; $display("FAIL arst_mpcnt got %0d want 0", mispredict_cnt); end
    #1 rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed();
    test_conditions();
    test_bht_saturation();
    test_illegal_and_jump();
    test_clr();
    test_stat_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-gate branch-and-zero decision.
- Resolves every RV32I conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU) and unconditional jumps from the operands, and drives take_branch as the PC-select for the core.
- Holds a direct-mapped branch history table (BHT) of 2-bit saturating counters that supplies predictions to fetch and is trained at resolve.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, number of BHT entries; power of 2, minimum 2; IDX_W = log2(BHT_DEPTH).
- CTR_INIT, 2'b01, reset state of every BHT counter (weakly not-taken).
- STAT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pred_pc  in  XLEN  fetch PC for lookup.
- pred_taken  out  1  combinational prediction for pred_pc.
- res_valid  in  1  an instruction resolves this cycle.
- res_pc  in  XLEN  PC of the resolving instruction.
- res_is_branch  in  1  conditional branch.
- res_is_jump  in  1  JAL/JALR.
- res_funct3  in  3  branch condition encoding.
- res_pred_taken  in  1  prediction that was issued for this instruction.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B.
- take_branch  out  1  combinational resolved outcome.
- mispredict  out  1  combinational: resolved outcome differs from res_pred_taken.
- illegal_cond  out  1  combinational: branch with funct3 010 or 011.
- clr_stats  in  1  synchronous clear of the statistics counters.
- branch_cnt  out  STAT_W  resolved conditional branches.
- mispredict_cnt  out  STAT_W  mispredicted conditional branches.

Behaviour:
- BHT index is pc[IDX_W+1:2]; bits [1:0] are ignored.
- pred_taken = bht[idx(pred_pc)][1]. Purely combinational from registered state; zero latency.
- Condition evaluation, only when res_valid=1 and res_is_branch=1:
  - 000: equal. 001: not equal.
  - 100: signed less-than. 101: signed greater-or-equal.
  - 110: unsigned less-than. 111: unsigned greater-or-equal.
  - 010/011: take_branch=0, illegal_cond=1, no BHT update, no counts.
- take_branch:
  - 1 whenever res_valid=1 and res_is_jump=1, regardless of res_is_branch.
  - 0 whenever res_valid=0.
- mispredict: asserted only for a legal conditional branch with take_branch != res_pred_taken. Always 0 for jumps.
- BHT update, on the clock edge after a legal conditional resolve:
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
  - Jumps never touch the BHT.
- Same index looked up and updated in the same cycle: pred_taken shows the pre-update value; the new value is visible the next cycle.
- Statistics:
  - branch_cnt +1 per legal conditional resolve.
  - mispredict_cnt +1 when mispredict=1.
  - Both saturate at all-ones with no wrap.
  - clr_stats has priority over increment in the same cycle; both counters read 0 next cycle.
- Reset, asynchronous and immediate, including mid-operation:
  - All BHT entries go to CTR_INIT.
  - branch_cnt = 0, mispredict_cnt = 0.
  - Combinational outputs follow their inputs; with the reset table, pred_taken = CTR_INIT[1] = 0.
- res_is_branch and res_is_jump both 1: treated as a jump.

Decomposition:
- Shared package branch_pkg:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Counter state constants SNT=00, WNT=01, WT=10, ST=11.
  - Saturating 2-bit next-state function.
- One sub-module, branch_cmp: combinational comparator (XLEN, funct3 -> cond_true, illegal).
- Table, update logic and statistics stay in the top level.

Test Plan:
- Reset then pred_pc=0x100 -> pred_taken=0. Stats read 0.
- BEQ, rs1=rs2=5, res_pred_taken=0 -> take_branch=1, mispredict=1. Next cycle bht[idx(0x100)]=WT, pred_taken=1, branch_cnt=1, mispredict_cnt=1.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> take_branch=1. BLTU with the same operands -> take_branch=0.
- Four taken resolves at PC 0x200 -> counter saturates at ST. One not-taken -> WT. A second not-taken -> WNT. PC 0x300 (same index at DEPTH=64) aliases this entry.
- funct3=010 with res_is_branch=1 -> illegal_cond=1, take_branch=0, BHT and counts unchanged. JAL -> take_branch=1, mispredict=0, counts unchanged.
- Preload branch_cnt to all-ones, resolve once -> stays all-ones.
- clr_stats asserted with a resolve in the same cycle -> both counters 0 next cycle.
- Assert rst_n=0 mid-sequence between edges -> BHT and counters clear immediately, without waiting for a clock edge.
